// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower converter feeding a small output FIFO.
// Optional statistics counters are built only when TO_LOWER_STATS_EN is defined.
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conv_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [AW:0]      level,
  output logic [CNT_W-1:0] conv_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  // Handshake: a byte moves only in a cycle where valid and ready are both 1;
  // valid never waits on ready, and ready/valid here depend only on registered level.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   level_n;
  logic [7:0]    head_q, head_src, wdata;
  logic          push, pop, is_conv;

  assign in_ready  = (level != (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign is_conv = conv_en && (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign wdata   = is_conv ? (in_data | 8'h20) : in_data;

  always_comb begin
    rd_ptr_n = rd_ptr;
    level_n  = level;
    if (pop) rd_ptr_n = rd_ptr + AW'(1);
    if (push && !pop) level_n = level + (AW+1)'(1);
    else if (!push && pop) level_n = level - (AW+1)'(1);
  end

  // The next head may be the byte being written this very cycle (empty, or one left and popped).
  assign head_src = (push && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head_q <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      if (level_n != '0) head_q <= head_src;
    end
  end

`ifdef TO_LOWER_STATS_EN
  logic [CNT_W-1:0] conv_q, byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_q <= '0;
      byte_q <= '0;
    end else begin
      if (push && (byte_q != '1)) byte_q <= byte_q + CNT_W'(1);
      if (push && is_conv && (conv_q != '1)) conv_q <= conv_q + CNT_W'(1);
    end
  end

  assign conv_cnt = conv_q;
  assign byte_cnt = byte_q;
`else
  assign conv_cnt = '0;
  assign byte_cnt = '0;
`endif

endmodule

// File: tb/tb_to_lower_stream.sv
// Directed bench for to_lower_stream; inputs driven and outputs sampled on the falling edge.
module tb_to_lower_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       conv_en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [3:0] conv_cnt;
  logic [3:0] byte_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  to_lower_stream #(.DEPTH(4), .AW(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .conv_en(conv_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .conv_cnt(conv_cnt), .byte_cnt(byte_cnt)
  );

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    cmp_cnt++;
    if (level !== 3'd0) begin err_cnt++; $display("FAIL reset_level: got %0d expected 0", level); end
    cmp_cnt++;
    if (out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_convert();
    logic [7:0] src [8] = '{8'h41, 8'h5A, 8'h61, 8'h40, 8'h5B, 8'hC1, 8'h00, 8'h4D};
    logic [7:0] exp [8] = '{8'h61, 8'h7A, 8'h61, 8'h40, 8'h5B, 8'hC1, 8'h00, 8'h6D};
    do_reset();
    conv_en   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        cmp_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp[i-1] || level !== 3'd1) begin
          err_cnt++;
          $display("FAIL convert[%0d]: got v=%b d=%h lvl=%0d expected v=1 d=%h lvl=1", i-1, out_valid, out_data, level, exp[i-1]);
        end
      end
      if (i < 8) begin in_valid = 1'b1; in_data = src[i]; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
    cmp_cnt++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin err_cnt++; $display("FAIL convert_empty: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, level); end
    cmp_cnt++;
    if (out_data !== 8'h6D) begin err_cnt++; $display("FAIL convert_hold: got %h expected 6d", out_data); end
`ifdef TO_LOWER_STATS_EN
    cmp_cnt++;
    if (byte_cnt !== 4'd8 || conv_cnt !== 4'd3) begin err_cnt++; $display("FAIL convert_stats: got b=%0d c=%0d expected b=8 c=3", byte_cnt, conv_cnt); end
`endif
  endtask

  task automatic test_passthrough();
    logic [7:0] src [2] = '{8'h48, 8'h49};
    do_reset();
    conv_en   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      if (i > 0) begin
        cmp_cnt++;
        if (out_valid !== 1'b1 || out_data !== src[i-1]) begin
          err_cnt++;
          $display("FAIL passthrough[%0d]: got v=%b d=%h expected v=1 d=%h", i-1, out_valid, out_data, src[i-1]);
        end
      end
      if (i < 2) begin in_valid = 1'b1; in_data = src[i]; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
`ifdef TO_LOWER_STATS_EN
    cmp_cnt++;
    if (byte_cnt !== 4'd2 || conv_cnt !== 4'd0) begin err_cnt++; $display("FAIL passthrough_stats: got b=%0d c=%0d expected b=2 c=0", byte_cnt, conv_cnt); end
`else
    cmp_cnt++;
    if (byte_cnt !== 4'd0 || conv_cnt !== 4'd0) begin err_cnt++; $display("FAIL stats_tied: got b=%0d c=%0d expected 0 0", byte_cnt, conv_cnt); end
`endif
    conv_en = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [7:0] src [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    logic [7:0] exp [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    logic did_push, did_pop;
    int k = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = src[i];
      @(negedge clk);
    end
    in_data = src[4];
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++;
      if (level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h61) begin
        err_cnt++;
        $display("FAIL full_hold[%0d]: got lvl=%0d rdy=%b v=%b d=%h expected lvl=4 rdy=0 v=1 d=61", i, level, in_ready, out_valid, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    cmp_cnt++;
    if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL full_no_refill: got rdy=%b expected 0", in_ready); end
    for (int c = 0; c < 20 && k < 5; c++) begin
      did_push = in_valid && in_ready;
      did_pop  = out_valid;
      if (did_pop) begin
        cmp_cnt++;
        if (out_data !== exp[k]) begin err_cnt++; $display("FAIL drain[%0d]: got %h expected %h", k, out_data, exp[k]); end
        k++;
      end
      @(negedge clk);
      if (did_push) in_valid = 1'b0;
    end
    cmp_cnt++;
    if (k !== 5 || level !== 3'd0 || in_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_done: got pops=%0d lvl=%0d pending=%b expected pops=5 lvl=0 pending=0", k, level, in_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] src [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                             8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C};
    logic [7:0] exp [12] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
                             8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = src[i];
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = src[c+2];
      cmp_cnt++;
      if (level !== 3'd2 || out_valid !== 1'b1 || out_data !== exp[c]) begin
        err_cnt++;
        $display("FAIL b2b[%0d]: got lvl=%0d v=%b d=%h expected lvl=2 v=1 d=%h", c, level, out_valid, out_data, exp[c]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 10; c < 12; c++) begin
      cmp_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp[c]) begin
        err_cnt++;
        $display("FAIL b2b_tail[%0d]: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, exp[c]);
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_empty: got lvl=%0d v=%b expected lvl=0 v=0", level, out_valid); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    cmp_cnt++;
    if (level !== 3'd3) begin err_cnt++; $display("FAIL mid_prefill: got lvl=%0d expected 3", level); end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'h00) begin
      err_cnt++;
      $display("FAIL mid_async: got v=%b lvl=%0d d=%h expected v=0 lvl=0 d=00", out_valid, level, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h51;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cmp_cnt++;
    if (level !== 3'd1 || out_valid !== 1'b1 || out_data !== 8'h71) begin
      err_cnt++;
      $display("FAIL mid_first: got lvl=%0d v=%b d=%h expected lvl=1 v=1 d=71", level, out_valid, out_data);
    end
    @(negedge clk);
    cmp_cnt++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_alone: got lvl=%0d v=%b expected lvl=0 v=0", level, out_valid); end
  endtask

  task automatic test_stats_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'h43;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
`ifdef TO_LOWER_STATS_EN
    cmp_cnt++;
    if (byte_cnt !== 4'hF || conv_cnt !== 4'hF) begin err_cnt++; $display("FAIL stats_sat: got b=%h c=%h expected f f", byte_cnt, conv_cnt); end
`else
    cmp_cnt++;
    if (byte_cnt !== 4'h0 || conv_cnt !== 4'h0) begin err_cnt++; $display("FAIL stats_off: got b=%h c=%h expected 0 0", byte_cnt, conv_cnt); end
`endif
    cmp_cnt++;
    if (out_data !== 8'h63 || level !== 3'd0) begin err_cnt++; $display("FAIL stats_stream: got d=%h lvl=%0d expected d=63 lvl=0", out_data, level); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_passthrough();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    test_stats_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
